angle_peak_finder: RTL and testbench

Consumes the 8-bit angle stream from the atan stage, where 256 codes make one full turn. It builds a coarse histogram of angles over a fixed window of samples, then scans the histogram for the dominant direction. It reports that direction as a bin index, a bin-centre angle and a hit count, with a one-cycle strobe. Downstream steering/control logic reads the report.

---
 rtl/angle_peak_finder_if.sv | 25 ++
 rtl/angle_peak_finder.sv | 142 ++++++++++++++
 tb/tb_angle_peak_finder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/angle_peak_finder_if.sv
// rtl/angle_peak_finder_if.sv - angle sample input and peak report bundle for angle_peak_finder
interface angle_peak_finder_if #(
  parameter int BIN_BITS = 5,
  parameter int COUNT_W  = 16
);
  logic                enable;
  logic                angle_valid;
  logic [7:0]          angle;
  logic                peak_valid;
  logic [BIN_BITS-1:0] peak_bin;
  logic [7:0]          peak_angle;
  logic [COUNT_W-1:0]  peak_count;
  logic                busy;
  logic                overrun;

  modport master (
    output enable, angle_valid, angle,
    input  peak_valid, peak_bin, peak_angle, peak_count, busy, overrun
  );

  modport slave (
    input  enable, angle_valid, angle,
    output peak_valid, peak_bin, peak_angle, peak_count, busy, overrun
  );
endinterface

// File: rtl/angle_peak_finder.sv
// rtl/angle_peak_finder.sv - windowed angle histogram with dominant-bin scan and report strobe
module angle_peak_finder #(
  parameter int BIN_BITS = 5,
  parameter int WINDOW   = 1024,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  angle_peak_finder_if.slave  bus
);
  localparam int                  NBINS    = 1 << BIN_BITS;
  localparam int                  SHIFT    = 8 - BIN_BITS;
  localparam logic [7:0]          HALF     = 8'(128 >> BIN_BITS);
  localparam logic [COUNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0]  WIN_LAST = COUNT_W'(WINDOW - 1);
  localparam logic [BIN_BITS-1:0] LAST_IDX = BIN_BITS'(NBINS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  bins_q [NBINS];
  logic [COUNT_W-1:0]  bins_d [NBINS];
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [COUNT_W-1:0]  max_q, max_d;
  logic [BIN_BITS-1:0] max_bin_q, max_bin_d;
  logic [BIN_BITS-1:0] idx_q, idx_d;
  logic                peak_valid_q, peak_valid_d;
  logic [BIN_BITS-1:0] peak_bin_q, peak_bin_d;
  logic [7:0]          peak_angle_q, peak_angle_d;
  logic [COUNT_W-1:0]  peak_count_q, peak_count_d;
  logic                overrun_q, overrun_d;

  logic                busy;
  logic                accept;
  logic                last_sample;
  logic [BIN_BITS-1:0] in_bin;
  logic [COUNT_W-1:0]  scan_val;
  logic                scan_wins;
  logic [BIN_BITS-1:0] fin_bin;
  logic [COUNT_W-1:0]  fin_cnt;

  assign busy        = (state_q == SCAN) || (state_q == CLEAR);
  assign accept      = (state_q == ACCUM) && bus.enable && bus.angle_valid;
  assign last_sample = (cnt_q == WIN_LAST);
  assign in_bin      = bus.angle[7 -: BIN_BITS];
  assign scan_val    = bins_q[idx_q];
  // Strictly greater keeps the earlier (lower) index on ties.
  assign scan_wins   = scan_val > max_q;
  assign fin_bin     = scan_wins ? idx_q : max_bin_q;
  assign fin_cnt     = scan_wins ? scan_val : max_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
      cnt_q        <= '0;
      max_q        <= '0;
      max_bin_q    <= '0;
      idx_q        <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_angle_q <= '0;
      peak_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bins_q       <= bins_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      max_bin_q    <= max_bin_d;
      idx_q        <= idx_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_angle_q <= peak_angle_d;
      peak_count_q <= peak_count_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = ACCUM;
      ACCUM: begin
        if (!bus.enable)                state_d = CLEAR;
        else if (accept && last_sample) state_d = SCAN;
      end
      SCAN:    if (idx_q == LAST_IDX) state_d = CLEAR;
      CLEAR:   state_d = bus.enable ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bins_d       = bins_q;
    cnt_d        = cnt_q;
    max_d        = max_q;
    max_bin_d    = max_bin_q;
    idx_d        = idx_q;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_angle_d = peak_angle_q;
    peak_count_d = peak_count_q;
    overrun_d    = overrun_q | (busy & bus.angle_valid);
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (bins_q[in_bin] != CNT_MAX) bins_d[in_bin] = bins_q[in_bin] + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last_sample) begin
            idx_d     = '0;
            max_d     = '0;
            max_bin_d = '0;
          end
        end
      end
      SCAN: begin
        max_d     = fin_cnt;
        max_bin_d = fin_bin;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          peak_valid_d = 1'b1;
          peak_bin_d   = fin_bin;
          peak_count_d = fin_cnt;
          peak_angle_d = (8'(fin_bin) << SHIFT) + HALF;
        end
      end
      CLEAR: begin
        for (int i = 0; i < NBINS; i++) bins_d[i] = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_angle = peak_angle_q;
  assign bus.peak_count = peak_count_q;
  assign bus.busy       = busy;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_angle_peak_finder.sv
// tb/tb_angle_peak_finder.sv - directed self-checking bench for angle_peak_finder
module tb_angle_peak_finder;
  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   pv_count = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   last_acc = 0;

  angle_peak_finder_if #(.BIN_BITS(5), .COUNT_W(16)) bus ();

  angle_peak_finder #(.BIN_BITS(5), .WINDOW(1024), .COUNT_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.peak_valid) pv_count <= pv_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      bus.angle_valid = 1'b1;
      bus.angle       = a;
      @(posedge clk);
      #1;
    end
    bus.angle_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_peak(input int budget, output int at_cyc);
    bit found = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.peak_valid) begin
        found  = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!found) check("peak_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pv"},    32'(bus.peak_valid), 32'd0);
    check({tag, "_bin"},   32'(bus.peak_bin),   32'd0);
    check({tag, "_angle"}, 32'(bus.peak_angle), 32'd0);
    check({tag, "_count"}, 32'(bus.peak_count), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_ovr"},   32'(bus.overrun),    32'd0);
  endtask

  initial begin
    int pk;
    int pv_snap;
    int reps;
    int prev;
    resetn          = 1'b0;
    bus.enable      = 1'b0;
    bus.angle_valid = 1'b0;
    bus.angle       = 8'h00;
    #3;
    check_outputs_zero("reset");
    tick(2);
    resetn = 1'b1;
    tick(1);

    // Idle: stream ignored, no overrun
    send(8'h45, 50);
    check("idle_pv", 32'(pv_count), 32'd0);
    check("idle_ovr", 32'(bus.overrun), 32'd0);

    // Single direction
    bus.enable = 1'b1;
    tick(1);
    send(8'h45, 1024);
    tick(1);
    check("t2_busy", 32'(bus.busy), 32'd1);
    wait_peak(100, pk);
    check("t2_lat",   32'(pk - last_acc), 32'd32);
    check("t2_bin",   32'(bus.peak_bin),   32'd8);
    check("t2_angle", 32'(bus.peak_angle), 32'd68);
    check("t2_count", 32'(bus.peak_count), 32'd1024);
    tick(1);
    check("t2_pulse", 32'(bus.peak_valid), 32'd0);
    check("t2_hold",  32'(bus.peak_count), 32'd1024);

    // Tie-break: lower bin wins
    send(8'h18, 512);
    send(8'hA0, 512);
    wait_peak(100, pk);
    check("t3_bin",   32'(bus.peak_bin),   32'd3);
    check("t3_angle", 32'(bus.peak_angle), 32'd28);
    check("t3_count", 32'(bus.peak_count), 32'd512);
    tick(1);

    // Wrap boundary
    for (int i = 0; i < 424; i++) begin
      send(8'hFF, 1);
      send(8'h00, 1);
    end
    send(8'hFF, 176);
    wait_peak(100, pk);
    check("t4_bin",   32'(bus.peak_bin),   32'd31);
    check("t4_angle", 32'(bus.peak_angle), 32'd252);
    check("t4_count", 32'(bus.peak_count), 32'd600);
    tick(1);
    check("t4_ovr", 32'(bus.overrun), 32'd0);

    // Continuous stream: drops while busy, fixed report spacing
    reps = 0;
    prev = -1;
    bus.angle_valid = 1'b1;
    bus.angle       = 8'h80;
    for (int i = 0; i < 4000 && reps < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.peak_valid) begin
        check("t5_bin",   32'(bus.peak_bin),   32'd16);
        check("t5_count", 32'(bus.peak_count), 32'd1024);
        if (prev >= 0) check("t5_spacing", 32'(cyc - prev), 32'd1057);
        prev = cyc;
        reps++;
      end
    end
    bus.angle_valid = 1'b0;
    check("t5_reps", 32'(reps), 32'd3);
    check("t5_ovr",  32'(bus.overrun), 32'd1);
    tick(1);

    // Abort mid-window then clean window
    send(8'h10, 500);
    bus.enable = 1'b0;
    pv_snap = pv_count;
    tick(40);
    check("t6_abort_pv", 32'(pv_count - pv_snap), 32'd0);
    check("t6_abort_busy", 32'(bus.busy), 32'd0);
    bus.enable = 1'b1;
    tick(1);
    send(8'h10, 1024);
    wait_peak(100, pk);
    check("t6_bin",   32'(bus.peak_bin),   32'd2);
    check("t6_angle", 32'(bus.peak_angle), 32'd20);
    check("t6_count", 32'(bus.peak_count), 32'd1024);
    tick(1);

    // Reset during SCAN discards the window
    send(8'h20, 1024);
    tick(10);
    check("t6_scan_busy", 32'(bus.busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_outputs_zero("midscan");
    #1;
    resetn = 1'b1;
    pv_snap = pv_count;
    tick(40);
    check("t6_rst_pv",    32'(pv_count - pv_snap), 32'd0);
    check("t6_rst_count", 32'(bus.peak_count), 32'd0);
    check("t6_rst_bin",   32'(bus.peak_bin),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
